id_hazard_sb: RTL and testbench
===============================

# id_hazard_sb

Parametrised register-hazard scoreboard for the decode stage of the npc pipeline. It tracks the destination registers of up to DEPTH in-flight instructions between ID and write-back. It stalls ID on read-after-write conflicts, or, when forwarding is compiled in, emits per-source bypass selects. It sits between the decoder outputs and the ID/EX pipeline register and drives the fetch/decode stall.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DEPTH, 3, pipeline slots from EX to write-back inclusive (1..8)
- PC_W, 64, width of id_pc
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  core clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_pc  in  PC_W  PC of ID instruction (debug/trace only)
- id_rs1_addr, id_rs2_addr  in  ADDR_W  source registers
- id_rs1_en, id_rs2_en  in  1  source actually read
- id_rd_addr  in  ADDR_W  destination register
- id_rd_wen  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load (result available only from slot 1 onward)
- flush  in  1  kill ID instruction and slot 0 (branch redirect)
- stall_o  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_rs1_sel, fwd_rs2_sel  out  $clog2(DEPTH+1)  0 = regfile, k = bypass from slot k-1
- busy_cnt  out  $clog2(DEPTH+1)  number of valid slots
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- State: per slot i in 0..DEPTH-1: sb_v[i], sb_addr[i], sb_ld[i]. Slot 0 = EX; slot DEPTH-1 = write-back.
- Every clock, slot i moves to slot i+1; slot DEPTH-1 retires. The regfile write is visible to ID the cycle after retirement.
- Insert into slot 0 when id_valid & !stall_o & !flush & id_rd_wen & id_rd_addr != 0. Otherwise slot 0 loads a bubble (v=0).
- flush: slot 0 is overwritten with a bubble in the same edge; older slots advance normally.
- Conflict on rsX: id_valid & id_rsX_en & addr != 0 & sb_v[i] & sb_addr[i] == addr, for some i.
- The youngest match (lowest i) wins for both stall decision and select.
- Without forwarding: stall_o = any conflict on rs1 or rs2; fwd selects are tied to 0.
- x0 never conflicts and is never inserted.
- busy_cnt = popcount(sb_v). stall_cnt increments on each cycle with stall_o=1 and saturates at all-ones.

## Timing
- stall_o and fwd selects are combinational from ID inputs and registered slot state. There is no added latency.
- Reset: all sb_v=0, stall_cnt=0. Therefore stall_o=0, fwd selects=0, busy_cnt=0 while rst_n=0. Asserting reset mid-operation discards all in-flight entries immediately.
- No forwarding: a consumer directly after its producer stalls exactly DEPTH cycles. A consumer two instructions behind stalls DEPTH-1 cycles, and so on.
- A conflict with slot DEPTH-1 only stalls 1 cycle; the next cycle reads the regfile.
- Simultaneous flush and stall: flush wins. No insert happens, and slot 0 is cleared.
- rs1 and rs2 hitting different slots: the stall is the OR of both; selects are independent.

## Configuration
- ID_HAZARD_FWD_EN defined: forwarding mode.
  - A conflict whose youngest match is slot 0 with sb_ld=1 stalls 1 cycle (load-use).
  - Every other conflict sets fwd_rsX_sel = i+1 with stall_o=0.
- ID_HAZARD_FWD_EN undefined: stall-only mode as above. Select outputs are constant 0 and the sb_ld tracking is removed.

## Structure
- Shared package id_hazard_pkg holds:
  - default ADDR_W
  - the FWD_SEL_RF = 0 constant
  - a function computing select width from DEPTH
- Sub-module id_hazard_match, instantiated once per source. It takes (addr, en, sb_v, sb_addr, sb_ld) and returns hit, youngest index, and load-hit flag.

## Test plan
DEPTH=3 in all cases.
- Stall-only, back-to-back: addi x5 then add x6,x5,x1 -> stall_o high 3 cycles, consumer issues on the 4th; stall_cnt=3.
- x0 and disabled source: producer rd=x0 followed by a reader of x0, then a reader with rs2_en=0 matching rd -> stall_o never asserts; busy_cnt stays 0 for the x0 producer.
- Flush: producer x7 enters slot 0, flush asserted the same cycle the consumer of x7 is in ID -> slot 0 cleared; the next consumer of x7 sees no stall.
- FWD_EN: alu writes x5, next instruction reads x5 -> stall_o=0, fwd_rs1_sel=1. One bubble later -> fwd_rs1_sel=2.
- FWD_EN load-use: lw x8 followed by a reader of x8 -> stall_o=1 for 1 cycle, then fwd_rs1_sel=2.
- Async reset with 3 valid slots: rst_n low mid-cycle -> busy_cnt=0 and stall_o=0 without waiting for a clock edge; stall_cnt=0.

Source files
------------

// File: rtl/id_hazard_pkg.sv
// id_hazard_pkg: shared constants and width helpers for the ID hazard scoreboard.
// Optional forwarding is selected by the ID_HAZARD_FWD_EN macro in id_hazard_sb.
package id_hazard_pkg;

  // Default register address width (32 architectural registers)
  localparam int ADDR_W_DEF = 5;

  // Select value meaning "read operand from the register file"
  localparam int FWD_SEL_RF = 0;

  // Width of a bypass select: values 0..DEPTH
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a slot index: values 0..DEPTH-1, never narrower than one bit
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_hazard_match.sv
// id_hazard_match: compares one source register against every scoreboard slot
// and reports whether it conflicts, which slot is the youngest match, and
// whether that youngest match is a load still sitting in slot 0.
module id_hazard_match
  import id_hazard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 3,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic                          i_en,
  input  logic [DEPTH-1:0]              i_sb_v,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  i_sb_addr,
  input  logic [DEPTH-1:0]              i_sb_ld,
  output logic                          o_hit,
  output logic [IDX_W-1:0]              o_idx,
  output logic                          o_ld_hit
);

  logic [DEPTH-1:0] w_slot_hit;
  logic             w_youngest_ld;

  // x0 is hard-wired zero, so it can never be a true dependency
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_slot_hit[gi] = i_en && (i_addr != '0) && i_sb_v[gi] &&
                              (i_sb_addr[gi] == i_addr);
    end
  endgenerate

  // Priority pick: scanning from oldest to youngest lets the lowest index win
  always_comb begin
    o_idx         = '0;
    w_youngest_ld = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_slot_hit[i]) begin
        o_idx         = IDX_W'(i);
        w_youngest_ld = i_sb_ld[i];
      end
    end
    o_hit    = |w_slot_hit;
    o_ld_hit = o_hit && (o_idx == '0) && w_youngest_ld;
  end

endmodule

// File: rtl/id_hazard_sb.sv
// id_hazard_sb: register-hazard scoreboard between decode and the ID/EX
// register. Slot 0 is EX, slot DEPTH-1 is write-back.
// Build option: define ID_HAZARD_FWD_EN to emit bypass selects instead of
// stalling (only load-use from slot 0 stalls). Undefined = stall-only mode.
module id_hazard_sb
  import id_hazard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 3,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [PC_W-1:0]          id_pc,
  input  logic [ADDR_W-1:0]        id_rs1_addr,
  input  logic [ADDR_W-1:0]        id_rs2_addr,
  input  logic                     id_rs1_en,
  input  logic                     id_rs2_en,
  input  logic [ADDR_W-1:0]        id_rd_addr,
  input  logic                     id_rd_wen,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall_o,
  output logic [sel_w(DEPTH)-1:0]  fwd_rs1_sel,
  output logic [sel_w(DEPTH)-1:0]  fwd_rs2_sel,
  output logic [sel_w(DEPTH)-1:0]  busy_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int SEL_W = sel_w(DEPTH);
  localparam int IDX_W = idx_w(DEPTH);

  logic [DEPTH-1:0]             r_sb_v;
  logic [DEPTH-1:0][ADDR_W-1:0] r_sb_addr;
  logic [DEPTH-1:0]             w_sb_ld;
  logic [CNT_W-1:0]             r_stall_cnt;

  logic [1:0][ADDR_W-1:0]       w_src_addr;
  logic [1:0]                   w_src_en;
  logic [1:0]                   w_hit;
  logic [1:0][IDX_W-1:0]        w_idx;
  logic [1:0]                   w_ld_hit;
  logic [1:0][SEL_W-1:0]        w_sel;
  logic                         w_ins;
  logic                         w_unused_sig;

  assign w_src_addr = {id_rs2_addr, id_rs1_addr};
  assign w_src_en   = {id_valid & id_rs2_en, id_valid & id_rs1_en};

  // One matcher per source operand
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      id_hazard_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_match (
        .i_addr    (w_src_addr[gi]),
        .i_en      (w_src_en[gi]),
        .i_sb_v    (r_sb_v),
        .i_sb_addr (r_sb_addr),
        .i_sb_ld   (w_sb_ld),
        .o_hit     (w_hit[gi]),
        .o_idx     (w_idx[gi]),
        .o_ld_hit  (w_ld_hit[gi])
      );
    end
  endgenerate

`ifdef ID_HAZARD_FWD_EN
  logic [DEPTH-1:0] r_sb_ld;
  assign w_sb_ld = r_sb_ld;

  // Only a load still in EX cannot be bypassed; everything else forwards
  assign stall_o = w_ld_hit[0] | w_ld_hit[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_sel
      assign w_sel[gi] = (w_hit[gi] && !w_ld_hit[gi]) ?
                         SEL_W'(w_idx[gi]) + SEL_W'(1) : SEL_W'(FWD_SEL_RF);
    end
  endgenerate

  // Load flag travels with its slot; a flush kills the EX occupant too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_ld <= '0;
    end else begin
      r_sb_ld[0] <= w_ins & id_is_load;
      for (int i = 1; i < DEPTH; i++) begin
        r_sb_ld[i] <= (i == 1 && flush) ? 1'b0 : r_sb_ld[i-1];
      end
    end
  end
`else
  assign w_sb_ld = '0;
  assign stall_o = w_hit[0] | w_hit[1];
  assign w_sel   = '0;
`endif

  // Trace-only and mode-dependent signals folded here to keep lint quiet
  assign w_unused_sig = ^{id_pc, id_is_load, w_idx, w_ld_hit};

  assign fwd_rs1_sel = w_sel[0];
  assign fwd_rs2_sel = w_sel[1];

  // x0 writes are architecturally void, so they never occupy a slot
  assign w_ins = id_valid & ~stall_o & ~flush & id_rd_wen & (id_rd_addr != '0);

  // Slot 0 takes the issuing instruction or a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_v[0]    <= 1'b0;
      r_sb_addr[0] <= '0;
    end else begin
      r_sb_v[0]    <= w_ins;
      r_sb_addr[0] <= id_rd_addr;
    end
  end

  // Older slots shift every cycle; on flush the EX occupant is killed, so
  // it becomes a bubble rather than advancing into slot 1
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sb_v[gi]    <= 1'b0;
          r_sb_addr[gi] <= '0;
        end else begin
          r_sb_v[gi]    <= (gi == 1 && flush) ? 1'b0 : r_sb_v[gi-1];
          r_sb_addr[gi] <= r_sb_addr[gi-1];
        end
      end
    end
  endgenerate

  // Occupancy is the popcount of the valid bits
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt = busy_cnt + SEL_W'(r_sb_v[i]);
    end
  end

  // Saturating stall-cycle counter for performance monitoring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_sb.sv
// tb_id_hazard_sb: directed-vector bench for id_hazard_sb with DEPTH=3.
// Expectations follow ID_HAZARD_FWD_EN when that macro is defined.
module tb_id_hazard_sb;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 3;
  localparam int PC_W    = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [ADDR_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic              id_rs1_en, id_rs2_en, id_rd_wen, id_is_load, flush;
  logic              stall_o;
  logic [1:0]        fwd_rs1_sel, fwd_rs2_sel, busy_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  id_hazard_sb #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_en   (id_rs1_en),
    .id_rs2_en   (id_rs2_en),
    .id_rd_addr  (id_rd_addr),
    .id_rd_wen   (id_rd_wen),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall_o     (stall_o),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .busy_cnt    (busy_cnt),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input bit v, input logic [4:0] r1, input bit e1,
                     input logic [4:0] r2, input bit e2, input logic [4:0] rd,
                     input bit we, input bit ld, input bit fl);
    id_valid    = v;
    id_rs1_addr = r1;
    id_rs1_en   = e1;
    id_rs2_addr = r2;
    id_rs2_en   = e2;
    id_rd_addr  = rd;
    id_rd_wen   = we;
    id_is_load  = ld;
    flush       = fl;
    id_pc       = id_pc + 64'd4;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH) @(posedge clk);
    #1;
  endtask

  // Check one ID cycle at the falling edge, then advance past the next rising edge
  task automatic tick(input string tag, input bit es, input int eb, input int s1, input int s2);
    @(negedge clk);
    check_val({tag, "/stall"}, stall_o, es);
    check_val({tag, "/busy"}, busy_cnt, eb);
    check_val({tag, "/sel1"}, fwd_rs1_sel, s1);
    check_val({tag, "/sel2"}, fwd_rs2_sel, s2);
    check_val({tag, "/scnt"}, stall_cnt, exp_cnt);
    $display("txn %s: stall=%0d busy=%0d sel1=%0d sel2=%0d scnt=%0d",
             tag, stall_o, busy_cnt, fwd_rs1_sel, fwd_rs2_sel, stall_cnt);
    @(posedge clk);
    #1;
    if (es && exp_cnt != CNT_MAX) exp_cnt++;
  endtask

  initial begin
    id_pc = '0;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check_val("rst/stall", stall_o, 0);
    check_val("rst/busy", busy_cnt, 0);
    check_val("rst/scnt", stall_cnt, 0);
    check_val("rst/sel1", fwd_rs1_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back producer x5, consumer add x6,x5,x1
    drv(1, 1, 1, 0, 0, 5, 1, 0, 0);
    tick("b2b_p", 0, 0, 0, 0);
    drv(1, 5, 1, 1, 1, 6, 1, 0, 0);
`ifdef ID_HAZARD_FWD_EN
    tick("b2b_c", 0, 1, 1, 0);
`else
    tick("b2b_c0", 1, 1, 0, 0);
    tick("b2b_c1", 1, 1, 0, 0);
    tick("b2b_c2", 1, 1, 0, 0);
    tick("b2b_c3", 0, 0, 0, 0);
    idle();
    tick("b2b_idle", 0, 1, 0, 0);
    check_val("b2b/scnt3", stall_cnt, 3);
`endif
    drain();

    // x0 producer, x0 reader, disabled rs2 matching a live rd
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick("x0_p", 0, 0, 0, 0);
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0);
    tick("x0_r", 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 9, 1, 0, 0);
    tick("x9_p", 0, 0, 0, 0);
    drv(1, 0, 1, 9, 0, 0, 0, 0, 0);
    tick("x9_dis", 0, 1, 0, 0);
    drain();

    // Flush kills the ID instruction and the x7 producer in EX
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
    tick("fl_p", 0, 0, 0, 0);
    drv(1, 7, 1, 0, 0, 13, 1, 0, 1);
`ifdef ID_HAZARD_FWD_EN
    tick("fl_c", 0, 1, 1, 0);
`else
    tick("fl_c", 1, 1, 0, 0);
`endif
    drv(1, 7, 1, 0, 0, 13, 1, 0, 0);
    tick("fl_c2", 0, 0, 0, 0);
    idle();
    tick("fl_idle", 0, 1, 0, 0);
    drain();

    // rs1 hits slot 1 (x10), rs2 hits slot 0 (x11)
    drv(1, 0, 0, 0, 0, 10, 1, 0, 0);
    tick("ds_p10", 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 11, 1, 0, 0);
    tick("ds_p11", 0, 1, 0, 0);
    drv(1, 10, 1, 11, 1, 0, 0, 0, 0);
`ifdef ID_HAZARD_FWD_EN
    tick("ds_c", 0, 2, 2, 1);
`else
    tick("ds_c0", 1, 2, 0, 0);
    tick("ds_c1", 1, 2, 0, 0);
    tick("ds_c2", 1, 1, 0, 0);
    tick("ds_c3", 0, 0, 0, 0);
`endif
    drain();

    // Consumer two behind its producer
    drv(1, 0, 0, 0, 0, 12, 1, 0, 0);
    tick("tb_p", 0, 0, 0, 0);
    idle();
    tick("tb_gap", 0, 1, 0, 0);
    drv(1, 12, 1, 0, 0, 0, 0, 0, 0);
`ifdef ID_HAZARD_FWD_EN
    tick("tb_c", 0, 1, 2, 0);
`else
    tick("tb_c0", 1, 1, 0, 0);
    tick("tb_c1", 1, 1, 0, 0);
    tick("tb_c2", 0, 0, 0, 0);
`endif
    drain();

`ifdef ID_HAZARD_FWD_EN
    // Load-use: one bubble, then bypass from slot 1
    drv(1, 0, 0, 0, 0, 8, 1, 1, 0);
    tick("lu_p", 0, 0, 0, 0);
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0);
    tick("lu_c0", 1, 1, 0, 0);
    tick("lu_c1", 0, 1, 2, 0);
    drain();
`else
    // Push the stall counter past its 4-bit ceiling
    for (int k = 0; k < 3; k++) begin
      drv(1, 0, 0, 0, 0, 20, 1, 0, 0);
      tick("sat_p", 0, 0, 0, 0);
      drv(1, 20, 1, 0, 0, 0, 0, 0, 0);
      tick("sat_c0", 1, 1, 0, 0);
      tick("sat_c1", 1, 1, 0, 0);
      tick("sat_c2", 1, 1, 0, 0);
      drain();
    end
    check_val("sat/scnt", stall_cnt, CNT_MAX);
`endif

    // Asynchronous reset with three live slots
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tick("ar_p1", 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0);
    tick("ar_p2", 0, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick("ar_p3", 0, 2, 0, 0);
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("ar/busy3", busy_cnt, 3);
`ifdef ID_HAZARD_FWD_EN
    check_val("ar/sel_pre", fwd_rs1_sel, 1);
`else
    check_val("ar/stall_pre", stall_o, 1);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar/busy", busy_cnt, 0);
    check_val("ar/stall", stall_o, 0);
    check_val("ar/scnt", stall_cnt, 0);
    check_val("ar/sel1", fwd_rs1_sel, 0);
    $display("txn async_reset: busy=%0d stall=%0d scnt=%0d", busy_cnt, stall_o, stall_cnt);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    tick("post_rst", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
